dp_ram_fifo_ctrl: RTL

- Sequencing controller that turns one external dual-port, synchronous-read block RAM (port 0 write-only, port 1 read-only) into a ready/valid streaming FIFO.
- Owns the write/read pointers and occupancy, and hides the RAM's 1-cycle registered read latency behind a 3-entry output buffer.
- Presents first-word-fall-through output at full throughput of one word per cycle.
- Sits between the stream producers/consumers and the RAM instance; drives every RAM port except clock.

---
 rtl/dp_ram_fifo_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl
// Wraps an external dual-port block RAM with synchronous reads into a
// first-word-fall-through ready/valid FIFO. The controller owns the RAM
// pointers and occupancy. A 3-entry output buffer hides the 1-cycle read
// latency so that one word per cycle can flow through.
module dp_ram_fifo_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] enq_data,
    input  logic              enq_valid,
    output logic              enq_ready,
    output logic [DWIDTH-1:0] deq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [AWIDTH+1:0] count,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic [DWIDTH-1:0] ram_d0,
    output logic              ram_we0,
    output logic [AWIDTH-1:0] ram_addr1,
    output logic [DWIDTH-1:0] ram_d1,
    output logic              ram_we1,
    input  logic [DWIDTH-1:0] ram_q1,
    output logic              ram_rst
);

    localparam logic [AWIDTH-1:0] PTR_ONE = 1;
    localparam logic [AWIDTH:0]   CNT_ONE = 1;

    logic [AWIDTH-1:0]           wr_ptr;
    logic [AWIDTH-1:0]           rd_ptr;
    logic [AWIDTH:0]             ram_cnt;
    logic                        rd_inflight;
    logic [1:0]                  buf_cnt;
    logic [2:0][DWIDTH-1:0]      buf_q;

    logic                        enq_fire;
    logic                        deq_fire;
    logic                        rd_issue;
    logic [1:0]                  cap_idx;
    logic [1:0]                  buf_cnt_nxt;
    logic [2:0][DWIDTH-1:0]      buf_nxt;

    // Handshake and read-issue decisions; all from registered state only.
    always_comb begin
        // ram_cnt never exceeds DEPTH, so its MSB alone flags "full".
        enq_ready = ~rst & ~ram_cnt[AWIDTH];
        enq_fire  = enq_valid & enq_ready;
        deq_valid = (buf_cnt != 2'd0);
        deq_fire  = deq_valid & deq_ready;
        rd_issue  = (ram_cnt != '0) &&
                    (({1'b0, buf_cnt} + {2'b00, rd_inflight}) < 3'd3);
    end

    // RAM port drive and visible occupancy.
    always_comb begin
        ram_addr0 = wr_ptr;
        ram_d0    = enq_data;
        ram_we0   = enq_fire;
        ram_addr1 = rd_ptr;
        ram_d1    = '0;
        ram_we1   = 1'b0;
        ram_rst   = rst;
        deq_data  = buf_q[0];
        count     = {1'b0, ram_cnt}
                  + {{(AWIDTH+1){1'b0}}, rd_inflight}
                  + {{AWIDTH{1'b0}}, buf_cnt};
    end

    // Output buffer next state: shift occupied entries on pop, then append
    // the captured RAM word behind the remaining ones. Unoccupied entries
    // are left untouched so the head keeps the last popped word when empty.
    always_comb begin
        buf_nxt = buf_q;
        cap_idx = buf_cnt - {1'b0, deq_fire};
        if (deq_fire) begin
            if (buf_cnt > 2'd1) buf_nxt[0] = buf_q[1];
            if (buf_cnt > 2'd2) buf_nxt[1] = buf_q[2];
        end
        if (rd_inflight) buf_nxt[cap_idx] = ram_q1;
        buf_cnt_nxt = buf_cnt - {1'b0, deq_fire} + {1'b0, rd_inflight};
    end

    // Pointer, occupancy and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            buf_cnt     <= '0;
            buf_q       <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq_fire, rd_issue})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase
            rd_inflight <= rd_issue;
            buf_cnt     <= buf_cnt_nxt;
            buf_q       <= buf_nxt;
        end
    end

endmodule
